// File: rtl/pac_sram_buffer.sv
// Simple dual-port staging buffer for the page-access-counter datapath.
// Byte-enable writes, per-entry written bits, selectable read-during-write and optional output register.
module pac_sram_buffer #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wren,
  input  logic [ADDR_WIDTH-1:0]   wraddress,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] byteena,
  input  logic                    clear,
  input  logic                    rden,
  input  logic [ADDR_WIDTH-1:0]   rdaddress,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  output logic                    q_written
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;

  logic                  wr_act_c;
  logic                  wr_old_w_c;
  logic [DATA_WIDTH-1:0] wmask_c;
  logic                  rd_old_w_c;
  logic [DATA_WIDTH-1:0] rd_old_c;
  logic                  rd_hit_c;
  logic [DATA_WIDTH-1:0] rd_val_c;
  logic                  rd_w_c;

  // Write qualification and byte mask; a clear in the same cycle makes the old entry count as unwritten.
  always_comb begin
    wr_act_c   = wren && (|byteena);
    wr_old_w_c = written[wraddress] & ~clear;
    wmask_c    = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      wmask_c[8*i +: 8] = {8{byteena[i]}};
    end
  end

  // Array update: a first write to an entry also zeroes its disabled bytes.
  always_ff @(posedge clock) begin
    if (wr_act_c) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (byteena[i] || !wr_old_w_c) begin
          mem[wraddress][8*i +: 8] <= byteena[i] ? data[8*i +: 8] : 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      written <= '0;
    end else begin
      if (clear) begin
        written <= '0;
      end
      if (wr_act_c) begin
        written[wraddress] <= 1'b1;
      end
    end
  end

  // Read data selection including same-address read-during-write.
  always_comb begin
    rd_old_w_c = written[rdaddress] & ~clear;
    rd_old_c   = rd_old_w_c ? mem[rdaddress] : '0;
    rd_hit_c   = wr_act_c && (wraddress == rdaddress);
    rd_val_c   = rd_old_c;
    rd_w_c     = rd_old_w_c;
    if (rd_hit_c && (RDW_MODE == 0)) begin
      rd_val_c = (data & wmask_c) | (rd_old_c & ~wmask_c);
      rd_w_c   = 1'b1;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] p_q;
      logic                  p_w;
      logic                  p_v;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          p_q       <= '0;
          p_w       <= 1'b0;
          p_v       <= 1'b0;
          q         <= '0;
          q_written <= 1'b0;
          q_valid   <= 1'b0;
        end else begin
          p_v     <= rden;
          q_valid <= p_v;
          if (rden) begin
            p_q <= rd_val_c;
            p_w <= rd_w_c;
          end
          if (p_v) begin
            q         <= p_q;
            q_written <= p_w;
          end
        end
      end
    end else begin : g_no_reg
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q         <= '0;
          q_written <= 1'b0;
          q_valid   <= 1'b0;
        end else begin
          q_valid <= rden;
          if (rden) begin
            q         <= rd_val_c;
            q_written <= rd_w_c;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pac_sram_buffer.sv
// Bench for pac_sram_buffer: two configurations (new-data/latency 1 and old-data/latency 2)
// driven in lockstep, checked against directed vectors and a logical-content reference model.
module tb_pac_sram_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wren;
  logic [AW-1:0] wa;
  logic [DW-1:0] d;
  logic [3:0]    be;
  logic          clear;
  logic          rden;
  logic [AW-1:0] ra;
  logic [DW-1:0] q0, q1;
  logic          v0, v1, w0, w1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pac_sram_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .wren(wren), .wraddress(wa), .data(d), .byteena(be),
    .clear(clear), .rden(rden), .rdaddress(ra), .q(q0), .q_valid(v0), .q_written(w0));

  pac_sram_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .wren(wren), .wraddress(wa), .data(d), .byteena(be),
    .clear(clear), .rden(rden), .rdaddress(ra), .q(q1), .q_valid(v1), .q_written(w1));

  // Reference: logical entry value (0 when unwritten) and written flag per address.
  logic [DW-1:0] m_ent [16];
  logic          m_wr  [16];
  logic [DW-1:0] e_q [2];
  logic          e_w [2];
  logic          e_v [2];
  logic [DW-1:0] p_q;
  logic          p_w, p_v;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_ent[i] = '0;
      m_wr[i]  = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      e_q[k] = '0; e_w[k] = 1'b0; e_v[k] = 1'b0;
    end
    p_q = '0; p_w = 1'b0; p_v = 1'b0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] mask, old, nv;
    logic          ow, wact, hit;
    if (!reset_n) return;
    mask = '0;
    for (int i = 0; i < 4; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
    wact = wren && (be != 4'h0);
    old  = clear ? '0 : m_ent[ra];
    ow   = clear ? 1'b0 : m_wr[ra];
    nv   = (d & mask) | ((clear ? '0 : m_ent[wa]) & ~mask);
    hit  = wact && (wa == ra);
    e_v[1] = p_v;
    if (p_v) begin e_q[1] = p_q; e_w[1] = p_w; end
    p_v = rden;
    if (rden) begin p_q = old; p_w = ow; end
    e_v[0] = rden;
    if (rden) begin
      e_q[0] = hit ? nv : old;
      e_w[0] = hit ? 1'b1 : ow;
    end
    if (clear) for (int i = 0; i < 16; i++) begin m_ent[i] = '0; m_wr[i] = 1'b0; end
    if (wact) begin m_ent[wa] = nv; m_wr[wa] = 1'b1; end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("q_valid0", DW'(v0), DW'(e_v[0]));
    chk("q0", q0, e_q[0]);
    chk("q_written0", DW'(w0), DW'(e_w[0]));
    chk("q_valid1", DW'(v1), DW'(e_v[1]));
    chk("q1", q1, e_q[1]);
    chk("q_written1", DW'(w1), DW'(e_w[1]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle();
    wren = 1'b0; be = 4'h0; clear = 1'b0; rden = 1'b0;
  endtask

  typedef struct {
    logic          wren;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic [3:0]    be;
    logic          clr;
    logic          rden;
    logic [AW-1:0] ra;
    logic [DW-1:0] q0;
    logic          w0;
    logic [DW-1:0] q1;
    logic          w1;
  } vec_t;

  vec_t vec [21];

  initial begin
    //            wren wa     data          be    clr   rden  ra     q0            w0    q1            w1
    vec[0]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd5,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[1]  = '{1'b1, 4'd3,  32'h0000AABB, 4'hF, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd3,  32'h0000AABB, 1'b1, 32'h0000AABB, 1'b1};
    vec[3]  = '{1'b1, 4'd7,  32'hFFFFFF5A, 4'h1, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[4]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd7,  32'h0000005A, 1'b1, 32'h0000005A, 1'b1};
    vec[5]  = '{1'b1, 4'd7,  32'hEEEE11CC, 4'h2, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[6]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd7,  32'h0000115A, 1'b1, 32'h0000115A, 1'b1};
    vec[7]  = '{1'b1, 4'd9,  32'h00000001, 4'hF, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[8]  = '{1'b1, 4'd9,  32'h00000002, 4'hF, 1'b0, 1'b1, 4'd9,  32'h00000002, 1'b1, 32'h00000001, 1'b1};
    vec[9]  = '{1'b1, 4'd0,  32'h11111111, 4'hF, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[10] = '{1'b1, 4'd15, 32'h22222222, 4'hF, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[11] = '{1'b1, 4'd4,  32'h00000044, 4'hF, 1'b1, 1'b1, 4'd4,  32'h00000044, 1'b1, 32'h0,        1'b0};
    vec[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[13] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd15, 32'h0,        1'b0, 32'h0,        1'b0};
    vec[14] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd4,  32'h00000044, 1'b1, 32'h00000044, 1'b1};
    vec[15] = '{1'b1, 4'd5,  32'h000000FF, 4'h0, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[16] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd5,  32'h0,        1'b0, 32'h0,        1'b0};
    vec[17] = '{1'b1, 4'd3,  32'hCCCCCC77, 4'h1, 1'b0, 1'b1, 4'd3,  32'h00000077, 1'b1, 32'h0,        1'b0};
    vec[18] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd3,  32'h00000077, 1'b1, 32'h00000077, 1'b1};
    vec[19] = '{1'b1, 4'd4,  32'h1234BB00, 4'h2, 1'b0, 1'b1, 4'd4,  32'h0000BB44, 1'b1, 32'h00000044, 1'b1};
    vec[20] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 1'b1, 4'd4,  32'h0000BB44, 1'b1, 32'h0000BB44, 1'b1};

    reset_n = 1'b0;
    wa = '0; d = '0; ra = '0;
    idle();
    model_reset();
    #12;
    check_all();
    reset_n = 1'b1;

    // Directed vectors: issue one cycle, then check each configuration at its own latency.
    for (int r = 0; r < 21; r++) begin
      wren = vec[r].wren; wa = vec[r].wa; d = vec[r].d; be = vec[r].be;
      clear = vec[r].clr; rden = vec[r].rden; ra = vec[r].ra;
      tick();
      idle();
      if (vec[r].rden) begin
        chk($sformatf("vec%0d valid0", r), DW'(v0), DW'(1));
        chk($sformatf("vec%0d valid1_early", r), DW'(v1), DW'(0));
        chk($sformatf("vec%0d q0", r), q0, vec[r].q0);
        chk($sformatf("vec%0d w0", r), DW'(w0), DW'(vec[r].w0));
      end
      tick();
      if (vec[r].rden) begin
        chk($sformatf("vec%0d valid1", r), DW'(v1), DW'(1));
        chk($sformatf("vec%0d q1", r), q1, vec[r].q1);
        chk($sformatf("vec%0d w1", r), DW'(w1), DW'(vec[r].w1));
        chk($sformatf("vec%0d valid0_hold", r), DW'(v0), DW'(0));
      end
    end

    // Randomized traffic with frequent address collisions.
    for (int c = 0; c < 400; c++) begin
      wren  = ($urandom_range(0, 1) == 1);
      wa    = AW'($urandom_range(0, 15));
      d     = $urandom;
      be    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 29) == 0);
      rden  = ($urandom_range(0, 2) != 0);
      ra    = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 15));
      tick();
    end

    // Reset asserted while reads are in flight.
    idle();
    for (int i = 0; i < 16; i++) begin
      wren = 1'b1; wa = AW'(i); d = 32'hA5A50000 | 32'(i); be = 4'hF;
      tick();
    end
    idle();
    rden = 1'b1; ra = 4'd2;
    tick();
    ra = 4'd3;
    tick();
    ra = 4'd4;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    tick();
    rden = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rden = 1'b1; ra = 4'd6;
    tick();
    rden = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pac_sram_buffer.md
Name: pac_sram_buffer

Overview:
- Parametrised simple dual-port SRAM buffer (one write port, one read port) for the page-access-counter datapath; the next-generation counter/staging buffer.
- Adds byte-enable writes, selectable read-during-write mode, optional output pipeline register, read-valid handshake, and a per-entry "written" bit array.
- Entries never written since reset or clear read as zero, so counter tables need no initialisation sweep.

Parameters:
- DATA_WIDTH, 512, entry width in bits; must be a multiple of 8.
- ADDR_WIDTH, 9, address width; DEPTH = 2**ADDR_WIDTH entries.
- RDW_MODE, 0, read-during-write to the same address: 0 = new (merged) data, 1 = old data.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wren  input  1  write strobe.
- wraddress  input  ADDR_WIDTH  write address.
- data  input  DATA_WIDTH  write data.
- byteena  input  DATA_WIDTH/8  per-byte write enable; bit i covers data[8i+7:8i].
- clear  input  1  synchronous clear of every written bit.
- rden  input  1  read strobe.
- rdaddress  input  ADDR_WIDTH  read address.
- q  output  DATA_WIDTH  read data.
- q_valid  output  1  one-cycle pulse marking q as valid for a read.
- q_written  output  1  written bit of the returned entry, aligned with q_valid.

Behaviour:
- Reset (asynchronous, reset_n low): q = 0, q_valid = 0, q_written = 0, all DEPTH written bits = 0, pipeline stages flushed. Memory array contents are not reset.
  - A read in flight when reset asserts is dropped; no q_valid pulse follows.
- Write (wren = 1):
  - Only bytes with byteena = 1 are updated.
  - If the entry's written bit is 0, the whole entry is written, with disabled bytes forced to 0.
  - The entry's written bit is set on the next edge.
  - wren with byteena = 0 is a no-op: written bit unchanged, memory unchanged.
- Read (rden = 1 at edge N):
  - q and q_written update at edge N+1+OUT_REG; q_valid is high for exactly that cycle.
  - If the written bit is 0, q = 0 regardless of array contents.
  - Back-to-back reads every cycle are supported; one result per cycle, in order.
  - With rden = 0, q and q_written hold their last value and q_valid = 0.
- Read-during-write, same address in the same cycle:
  - RDW_MODE 0: q = (data & byte mask) | (old entry & ~mask), where old entry = 0 if not previously written; q_written = 1 unless byteena = 0.
  - RDW_MODE 1: q = pre-write entry (0 if unwritten); q_written = pre-write bit.
  - Different addresses: no interaction.
- Clear (clear = 1 at edge N): all written bits are 0 after edge N.
  - Same-cycle write: the write wins for its address (written bit = 1 afterwards).
  - Same-cycle read: returns 0 with q_written = 0, except a same-address write in RDW_MODE 0, which returns the merged value with the old entry taken as 0.
- Address wrap: addresses are ADDR_WIDTH bits with no out-of-range case; DEPTH-1 and 0 are independent entries.
- No back-pressure: the consumer must accept q on the q_valid cycle.

Test Plan:
- Reset, then read addr 5 -> q = 0, q_written = 0, q_valid pulses 1 cycle later (2 if OUT_REG = 1).
- Write addr 3 data = 0x..AABB, byteena = all ones; read addr 3 next cycle -> q = 0x..AABB, q_written = 1.
- Unwritten addr 7: write byteena = 0x1, data byte0 = 0x5A -> read gives q = 0x5A, all other bytes 0. Then write byteena = 0x2, byte1 = 0x11 -> q = 0x115A.
- Same-cycle write and read of addr 9 (entry previously 0x01, new 0x02, full mask) -> RDW_MODE 0: q = 0x02; RDW_MODE 1: q = 0x01.
- Write addrs 0 and DEPTH-1, pulse clear with a same-cycle write to addr 4 -> reads return 0 for addrs 0 and DEPTH-1, and the data for addr 4 with q_written = 1.
- Issue rden on 3 consecutive cycles, assert reset_n low mid-stream -> q_valid never rises for the remaining reads; q = 0 immediately.
